sram_dp_be: RTL and testbench

- Parametrised successor of the single-port synchronous SRAM, used as unified instruction/data memory for the ARM core.
- Port A: read/write with per-byte write enables, for the data side.
- Port B: read-only, for instruction fetch.
- Adds read-during-write control, an optional hardware zero-fill after reset with a BUSY flag, and optional per-byte parity.

---
 rtl/sram_dp_be.sv | 148 ++++++++++++++
 tb/tb_sram_dp_be.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_be.sv
// Dual-port synchronous SRAM: port A read/write with byte enables, port B read-only.
// Optional zero-fill after reset (BUSY); per-byte even parity when SRAM_PARITY_EN is defined.
module sram_dp_be #(
  parameter string ROMDATA        = "",
  parameter int    AWIDTH         = 10,
  parameter int    DEPTH          = 1024,
  parameter int    WIDTH          = 32,
  parameter int    RDW_MODE       = 0,
  parameter int    CLEAR_ON_RESET = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [AWIDTH-1:0]    ADDRA,
  input  logic                 ENA,
  input  logic [WIDTH/8-1:0]   WEA,
  input  logic [WIDTH-1:0]     DIA,
  output logic [WIDTH-1:0]     DOA,
  input  logic [AWIDTH-1:0]    ADDRB,
  input  logic                 ENB,
  output logic [WIDTH-1:0]     DOB,
  output logic                 BUSY
`ifdef SRAM_PARITY_EN
  ,
  output logic [1:0]           PERR
`endif
);

  localparam int NBYTE = WIDTH / 8;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit CLR_EN = (ROMDATA == "") && (CLEAR_ON_RESET != 0);
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef SRAM_PARITY_EN
  logic [NBYTE-1:0] par_mem [DEPTH];
`endif

  logic [0:0]        state;
  logic [AWIDTH-1:0] clr_addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= CLR_EN ? ST_CLEAR : ST_IDLE;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == LAST) state <= ST_IDLE;
      clr_addr <= clr_addr + 1'b1;
    end
  end

  assign BUSY = (state == ST_CLEAR);

  logic             live, clearing, a_ok, b_ok, hit;
  logic [IW-1:0]    a_idx, b_idx, clr_idx;
  logic [NBYTE-1:0] a_wr;
  logic [WIDTH-1:0] a_word, b_word, a_rd, b_rd;

  assign live     = (state == ST_IDLE) && !RST;
  assign clearing = (state == ST_CLEAR) && !RST;
  assign a_ok     = {1'b0, ADDRA} < DEPTH_W;
  assign b_ok     = {1'b0, ADDRB} < DEPTH_W;
  assign hit      = (ADDRA == ADDRB);
  assign a_idx    = ADDRA[IW-1:0];
  assign b_idx    = ADDRB[IW-1:0];
  assign clr_idx  = clr_addr[IW-1:0];

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    a_wr   = (live && ENA && a_ok) ? WEA : '0;
    a_word = a_ok ? mem[a_idx] : '0;
    b_word = b_ok ? mem[b_idx] : '0;
    a_rd   = a_word;
    b_rd   = b_word;
    // Write-first bypass, per byte, for port A and for a same-address port B read.
    for (int i = 0; i < NBYTE; i++) begin
      if (RDW_MODE != 0 && a_wr[i])        a_rd[8*i +: 8] = DIA[8*i +: 8];
      if (RDW_MODE != 0 && a_wr[i] && hit) b_rd[8*i +: 8] = DIA[8*i +: 8];
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NBYTE-1:0] a_par, b_par;
  logic             a_err, b_err;

  always_comb begin
    a_par = a_ok ? par_mem[a_idx] : '0;
    b_par = b_ok ? par_mem[b_idx] : '0;
    a_err = 1'b0;
    b_err = 1'b0;
    for (int i = 0; i < NBYTE; i++) begin
      if (RDW_MODE != 0 && a_wr[i])        a_par[i] = ^DIA[8*i +: 8];
      if (RDW_MODE != 0 && a_wr[i] && hit) b_par[i] = ^DIA[8*i +: 8];
      a_err = a_err | ((^a_rd[8*i +: 8]) ^ a_par[i]);
      b_err = b_err | ((^b_rd[8*i +: 8]) ^ b_par[i]);
    end
    a_err = a_err && a_ok;
    b_err = b_err && b_ok;
  end
`endif

  // NOTE: the array has no reset; only the CLEAR sweep or a port A write changes its contents.
  always_ff @(posedge CLK) begin
    if (clearing) begin
      mem[clr_idx] <= '0;
`ifdef SRAM_PARITY_EN
      par_mem[clr_idx] <= '0;
`endif
    end else begin
      for (int i = 0; i < NBYTE; i++) begin
        if (a_wr[i]) begin
          mem[a_idx][8*i +: 8] <= DIA[8*i +: 8];
`ifdef SRAM_PARITY_EN
          par_mem[a_idx][i] <= ^DIA[8*i +: 8];
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOA <= '0;
      DOB <= '0;
`ifdef SRAM_PARITY_EN
      PERR <= '0;
`endif
    end else begin
      if (live && ENA) begin
        DOA <= a_rd;
`ifdef SRAM_PARITY_EN
        PERR[0] <= a_err;
`endif
      end
      if (live && ENB) begin
        DOB <= b_rd;
`ifdef SRAM_PARITY_EN
        PERR[1] <= b_err;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench for sram_dp_be: a read-first/clearing instance and a write-first/non-clearing
// instance share the same stimulus; expectations are queued and checked by a negedge monitor.
module tb_sram_dp_be;

  logic        CLK = 1'b0;
  logic        rst;
  logic [4:0]  addra, addrb;
  logic        ena, enb;
  logic [3:0]  wea;
  logic [31:0] dia;
  logic [31:0] doa0, dob0, doa1, dob1;
  logic        busy0, busy1;
`ifdef SRAM_PARITY_EN
  logic [1:0]  perr0, perr1;
`endif

  always #5 CLK = ~CLK;

  sram_dp_be #(.AWIDTH(5), .DEPTH(16), .WIDTH(32), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .CLK(CLK), .RST(rst), .ADDRA(addra), .ENA(ena), .WEA(wea), .DIA(dia), .DOA(doa0),
    .ADDRB(addrb), .ENB(enb), .DOB(dob0), .BUSY(busy0)
`ifdef SRAM_PARITY_EN
    , .PERR(perr0)
`endif
  );

  sram_dp_be #(.AWIDTH(5), .DEPTH(16), .WIDTH(32), .RDW_MODE(1), .CLEAR_ON_RESET(0)) dut1 (
    .CLK(CLK), .RST(rst), .ADDRA(addra), .ENA(ena), .WEA(wea), .DIA(dia), .DOA(doa1),
    .ADDRB(addrb), .ENB(enb), .DOB(dob1), .BUSY(busy1)
`ifdef SRAM_PARITY_EN
    , .PERR(perr1)
`endif
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return doa0;
      1: return dob0;
      2: return doa1;
      3: return dob1;
      4: return {31'b0, busy0};
      6: return {31'b0, busy1};
`ifdef SRAM_PARITY_EN
      5: return {30'b0, perr0};
`endif
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < q.size(); ) begin
      if (q[i].due <= cyc) begin
        check(q[i].name, actual(q[i].sel), q[i].exp);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  // sel: 0 doa0, 1 dob0, 2 doa1, 3 dob1, 4 busy0, 5 perr0, 6 busy1; lat 0 = before next edge.
  task automatic expect_at(string nm, int sel, logic [31:0] v, int lat);
    exp_t e;
    e.name = nm; e.sel = sel; e.exp = v; e.due = cyc + lat;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic busy_window(input bit try_write);
    for (int k = 0; k <= 16; k++) begin
      expect_at($sformatf("busy_k%0d", k), 4, (k < 16) ? 32'd1 : 32'd0, 0);
      if (try_write && k == 15) begin
        ena = 1'b1; wea = 4'hF; addra = 5'd4; dia = 32'h5555_5555;
      end else begin
        ena = 1'b0; wea = 4'h0;
      end
      tick();
    end
    ena = 1'b0; wea = 4'h0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = 4'h0; dia = '0; addra = '0; addrb = '0;
    tick(); tick();
    expect_at("rst_doa", 0, 32'h0, 0);
    expect_at("rst_dob", 1, 32'h0, 0);
    expect_at("rst_busy_clr", 4, 32'd1, 0);
    expect_at("rst_busy_noclr", 6, 32'd0, 0);
    rst = 1'b0;
    busy_window(1'b1);

    ena = 1'b1; addra = 5'd4; enb = 1'b1; addrb = 5'd5;
    expect_at("clr_a4_blocked_wr", 0, 32'h0, 1);
    expect_at("clr_b5", 1, 32'h0, 1);
    expect_at("noclr_wr_lands", 2, 32'h5555_5555, 1);
    tick();
    enb = 1'b0;

    wea = 4'hF; addra = 5'd3; dia = 32'hDEAD_BEEF;
    expect_at("full_wr_rf", 0, 32'h0, 1);
    expect_at("full_wr_wf", 2, 32'hDEAD_BEEF, 1);
    tick();
    wea = 4'h2; dia = 32'h0000_1100;
    expect_at("byte_wr_rf", 0, 32'hDEAD_BEEF, 1);
    expect_at("byte_wr_wf", 2, 32'hDEAD_11EF, 1);
    tick();
    wea = 4'h0;
    expect_at("byte_rd_rf", 0, 32'hDEAD_11EF, 1);
    expect_at("byte_rd_wf", 2, 32'hDEAD_11EF, 1);
    tick();
    ena = 1'b0; addra = 5'd9;
    expect_at("doa_hold", 0, 32'hDEAD_11EF, 1);
    tick();

    ena = 1'b1; wea = 4'hF; addra = 5'd7; dia = 32'hAAAA_AAAA;
    tick();
    dia = 32'h1234_5678; enb = 1'b1; addrb = 5'd7;
    expect_at("coll_dob_rf", 1, 32'hAAAA_AAAA, 1);
    expect_at("coll_dob_wf", 3, 32'h1234_5678, 1);
    expect_at("coll_doa_rf", 0, 32'hAAAA_AAAA, 1);
    expect_at("coll_doa_wf", 2, 32'h1234_5678, 1);
    tick();
    wea = 4'h1; dia = 32'h0000_00FF;
    expect_at("coll_byte_rf", 1, 32'h1234_5678, 1);
    expect_at("coll_byte_wf", 3, 32'h1234_56FF, 1);
    tick();
    ena = 1'b0; wea = 4'h0;
    expect_at("coll_after_rf", 1, 32'h1234_56FF, 1);
    expect_at("coll_after_wf", 3, 32'h1234_56FF, 1);
    tick();

    ena = 1'b1; wea = 4'hF; addra = 5'd2; dia = 32'h0BAD_F00D; enb = 1'b0;
    tick();
    ena = 1'b0; wea = 4'h0; enb = 1'b1; addrb = 5'd2;
    expect_at("enb_rd_rf", 1, 32'h0BAD_F00D, 1);
    expect_at("enb_rd_wf", 3, 32'h0BAD_F00D, 1);
    tick();
    enb = 1'b0; addrb = 5'd9;
    expect_at("dob_hold1", 1, 32'h0BAD_F00D, 1);
    tick();
    addrb = 5'd11;
    expect_at("dob_hold2", 1, 32'h0BAD_F00D, 1);
    tick();

    ena = 1'b1; wea = 4'hF; addra = 5'd20; dia = 32'hFFFF_FFFF;
    expect_at("oor_wr_rd_wf", 2, 32'h0, 1);
    tick();
    wea = 4'h0; enb = 1'b1; addrb = 5'd4;
    expect_at("oor_rd_a", 0, 32'h0, 1);
    expect_at("nowrap_b_rf", 1, 32'h0, 1);
    expect_at("nowrap_b_wf", 3, 32'h5555_5555, 1);
    tick();
    enb = 1'b1; addrb = 5'd20; ena = 1'b0;
    expect_at("oor_rd_b", 3, 32'h0, 1);
    tick();
    enb = 1'b0;

`ifdef SRAM_PARITY_EN
    ena = 1'b1; wea = 4'hF; addra = 5'd1; dia = 32'h0000_00FF;
    tick();
    dut0.par_mem[1][0] = ~dut0.par_mem[1][0];
    wea = 4'h0; enb = 1'b1; addrb = 5'd2;
    expect_at("par_err_a", 5, 32'd1, 1);
    expect_at("par_data_a", 0, 32'h0000_00FF, 1);
    tick();
    ena = 1'b0;
    expect_at("par_hold_a", 5, 32'd1, 1);
    tick();
    ena = 1'b1; wea = 4'hF; enb = 1'b0;
    expect_at("par_rewrite_rf", 5, 32'd1, 1);
    tick();
    wea = 4'h0;
    expect_at("par_clean_a", 5, 32'd0, 1);
    tick();
    ena = 1'b0;
`endif

    rst = 1'b1;
    tick();
    expect_at("rst2_doa", 0, 32'h0, 0);
    expect_at("rst2_dob", 1, 32'h0, 0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      expect_at($sformatf("busy_mid%0d", k), 4, 32'd1, 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_window(1'b0);

    for (int a = 0; a < 16; a++) begin
      ena = 1'b1; addra = 5'(a); enb = 1'b1; addrb = 5'(15 - a);
      expect_at($sformatf("reclr_a%0d", a), 0, 32'h0, 1);
      expect_at($sformatf("reclr_b%0d", 15 - a), 1, 32'h0, 1);
      tick();
    end
    ena = 1'b0; enb = 1'b0;

    repeat (4) tick();
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
